// File: rtl/int_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : int_sequencer_pkg
// Description : Shared CPU constants for the interrupt sequencer and fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package int_sequencer_pkg;

  localparam int CPU_ADDR_W     = 27;
  localparam int CPU_INT_VECTOR = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ISR  = 2'd2;
  localparam logic [1:0] ST_RET  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_PEND = ST_PEND,
    S_ISR  = ST_ISR,
    S_RET  = ST_RET
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : int_sequencer
// Description : Takes one interrupt at an instruction boundary, redirects fetch
//               to the ISR vector and restores the resume PC on RETI.
// Revision    : 1.0 - initial release
// ============================================================================
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int INT_VECTOR = CPU_INT_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic [7:0]        int_req_id,
  input  logic              gie_we,
  input  logic              gie_wdata,
  input  logic              bnd_valid,
  input  logic [ADDR_W-1:0] bnd_pc,
  input  logic              reti_exec,
  output logic              int_disabled,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              in_isr,
  output logic [7:0]        cur_int_id,
  output logic [ADDR_W-1:0] saved_pc
);

  localparam logic [ADDR_W-1:0] C_VECTOR = ADDR_W'($unsigned(INT_VECTOR));

  seq_state_t        r_state, w_state_nxt;
  logic              r_gie, w_gie_nxt;
  logic              r_int_disabled, w_int_disabled_nxt;
  logic              r_redirect, w_redirect_nxt;
  logic [ADDR_W-1:0] r_redirect_pc, w_redirect_pc_nxt;
  logic              r_in_isr, w_in_isr_nxt;
  logic [7:0]        r_cur_int_id, w_cur_int_id_nxt;
  logic [ADDR_W-1:0] r_saved_pc, w_saved_pc_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_gie          <= 1'b0;
      r_int_disabled <= 1'b1;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
      r_in_isr       <= 1'b0;
      r_cur_int_id   <= '0;
      r_saved_pc     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_gie          <= w_gie_nxt;
      r_int_disabled <= w_int_disabled_nxt;
      r_redirect     <= w_redirect_nxt;
      r_redirect_pc  <= w_redirect_pc_nxt;
      r_in_isr       <= w_in_isr_nxt;
      r_cur_int_id   <= w_cur_int_id_nxt;
      r_saved_pc     <= w_saved_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_gie_nxt         = gie_we ? gie_wdata : r_gie;
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_in_isr_nxt      = r_in_isr;
    w_cur_int_id_nxt  = r_cur_int_id;
    w_saved_pc_nxt    = r_saved_pc;

    case (r_state)
      // Acceptance is gated by the registered int_disabled, i.e. the old gie.
      S_IDLE: begin
        if (int_req && !r_int_disabled) begin
          w_cur_int_id_nxt = int_req_id;
          w_state_nxt      = S_PEND;
        end
      end
      S_PEND: begin
        if (bnd_valid) begin
          w_saved_pc_nxt    = bnd_pc;
          w_redirect_nxt    = 1'b1;
          w_redirect_pc_nxt = C_VECTOR;
          w_in_isr_nxt      = 1'b1;
          w_state_nxt       = S_ISR;
        end
      end
      S_ISR: begin
        if (reti_exec) begin
          w_redirect_nxt    = 1'b1;
          w_redirect_pc_nxt = r_saved_pc;
          w_state_nxt       = S_RET;
        end
      end
      S_RET: begin
        w_in_isr_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Computed from next-state values so the output is high the cycle after acceptance.
    w_int_disabled_nxt = (w_state_nxt != S_IDLE) || !w_gie_nxt;
  end

  assign int_disabled = r_int_disabled;
  assign redirect     = r_redirect;
  assign redirect_pc  = r_redirect_pc;
  assign in_isr       = r_in_isr;
  assign cur_int_id   = r_cur_int_id;
  assign saved_pc     = r_saved_pc;

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_sequencer
// Description : Directed vector bench for int_sequencer with hand-written
//               queued-interrupt sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_sequencer;

  localparam int ADDR_W = 27;

  logic              clk = 1'b0;
  logic              reset;
  logic              int_req;
  logic [7:0]        int_req_id;
  logic              gie_we;
  logic              gie_wdata;
  logic              bnd_valid;
  logic [ADDR_W-1:0] bnd_pc;
  logic              reti_exec;
  logic              int_disabled;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              in_isr;
  logic [7:0]        cur_int_id;
  logic [ADDR_W-1:0] saved_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_sequencer #(.ADDR_W(ADDR_W), .INT_VECTOR(1)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .int_req_id(int_req_id),
    .gie_we(gie_we), .gie_wdata(gie_wdata), .bnd_valid(bnd_valid),
    .bnd_pc(bnd_pc), .reti_exec(reti_exec), .int_disabled(int_disabled),
    .redirect(redirect), .redirect_pc(redirect_pc), .in_isr(in_isr),
    .cur_int_id(cur_int_id), .saved_pc(saved_pc)
  );

  typedef struct {
    logic        rst, req;
    logic [7:0]  id;
    logic        gwe, gwd, bv;
    logic [31:0] pc;
    logic        reti;
    logic        e_dis, e_red;
    logic [31:0] e_rpc;
    logic        e_isr;
    logic [7:0]  e_id;
    logic [31:0] e_spc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic req, logic [7:0] id, logic gwe, logic gwd,
                              logic bv, logic [31:0] pc, logic reti, logic e_dis, logic e_red,
                              logic [31:0] e_rpc, logic e_isr, logic [7:0] e_id, logic [31:0] e_spc);
    vec_t v;
    v.rst = rst; v.req = req; v.id = id; v.gwe = gwe; v.gwd = gwd; v.bv = bv;
    v.pc = pc; v.reti = reti; v.e_dis = e_dis; v.e_red = e_red; v.e_rpc = e_rpc;
    v.e_isr = e_isr; v.e_id = e_id; v.e_spc = e_spc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; int_req = 1'b0; int_req_id = '0; gie_we = 1'b0; gie_wdata = 1'b0;
    bnd_valid = 1'b0; bnd_pc = '0; reti_exec = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // Reset, basic take/return, stray RETI
    vecs.push_back(mk(1,0,0,0,0,0,0,0,          1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,          0,0,0,0,0,0));
    vecs.push_back(mk(0,1,3,0,0,1,'h100,0,      1,0,0,0,3,0));
    vecs.push_back(mk(0,1,3,0,0,1,'h100,0,      1,1,1,1,3,'h100));
    vecs.push_back(mk(0,0,0,0,0,1,'h104,0,      1,0,1,1,3,'h100));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,          1,1,'h100,1,3,'h100));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,          0,0,'h100,0,3,'h100));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,          0,0,'h100,0,3,'h100));
    // Boundary stall (RETI during PEND ignored; boundary beats RETI)
    vecs.push_back(mk(0,1,7,0,0,0,0,0,          1,0,'h100,0,7,'h100));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,0,0,'h2A0,(i == 2), 1,0,'h100,0,7,'h100));
    vecs.push_back(mk(0,0,0,0,0,1,'h2A0,1,      1,1,1,1,7,'h2A0));
    vecs.push_back(mk(0,1,9,0,0,1,'h2A4,0,      1,0,1,1,7,'h2A0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,          1,1,'h2A0,1,7,'h2A0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,          0,0,'h2A0,0,7,'h2A0));
    // Global enable
    vecs.push_back(mk(0,0,0,1,0,0,0,0,          1,0,'h2A0,0,7,'h2A0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,          1,0,'h2A0,0,7,'h2A0));
    vecs.push_back(mk(0,1,1,1,1,0,0,0,          0,0,'h2A0,0,7,'h2A0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,          1,0,'h2A0,0,1,'h2A0));
    vecs.push_back(mk(0,0,0,1,0,0,0,0,          1,0,'h2A0,0,1,'h2A0));
    vecs.push_back(mk(0,0,0,0,0,1,'h3C4,0,      1,1,1,1,1,'h3C4));
    vecs.push_back(mk(0,0,0,0,0,0,0,1,          1,1,'h3C4,1,1,'h3C4));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,          1,0,'h3C4,0,1,'h3C4));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,          0,0,'h3C4,0,1,'h3C4));
    // Reset while in ISR with a redirect pulse outstanding
    vecs.push_back(mk(0,1,4,0,0,1,'h055,0,      1,0,'h3C4,0,4,'h3C4));
    vecs.push_back(mk(0,1,4,0,0,1,'h055,0,      1,1,1,1,4,'h055));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,          1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,          1,0,0,0,0,0));
    vecs.push_back(mk(0,1,6,0,0,0,0,0,          1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,0,          0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; int_req = vecs[i].req; int_req_id = vecs[i].id;
      gie_we = vecs[i].gwe; gie_wdata = vecs[i].gwd; bnd_valid = vecs[i].bv;
      bnd_pc = vecs[i].pc[ADDR_W-1:0]; reti_exec = vecs[i].reti;
      step();
      chk($sformatf("row%0d.int_disabled", i), 32'(int_disabled), 32'(vecs[i].e_dis));
      chk($sformatf("row%0d.redirect", i),     32'(redirect),     32'(vecs[i].e_red));
      chk($sformatf("row%0d.redirect_pc", i),  32'(redirect_pc),  vecs[i].e_rpc);
      chk($sformatf("row%0d.in_isr", i),       32'(in_isr),       32'(vecs[i].e_isr));
      chk($sformatf("row%0d.cur_int_id", i),   32'(cur_int_id),   32'(vecs[i].e_id));
      chk($sformatf("row%0d.saved_pc", i),     32'(saved_pc),     vecs[i].e_spc);
    end

    // Queued request: int5 raised during the ISR of int2
    idle_inputs();
    int_req = 1'b1; int_req_id = 8'd2; bnd_valid = 1'b1; bnd_pc = 27'h500;
    step();
    chk("q.accept_id2", 32'(cur_int_id), 32'd2);
    step();
    chk("q.take_redirect", 32'(redirect), 32'd1);
    chk("q.take_pc", 32'(redirect_pc), 32'd1);
    int_req = 1'b1; int_req_id = 8'd5; bnd_pc = 27'h600;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("q.isr_no_redirect%0d", i), 32'(redirect), 32'd0);
      chk($sformatf("q.isr_id_hold%0d", i), 32'(cur_int_id), 32'd2);
    end
    reti_exec = 1'b1;
    step();
    reti_exec = 1'b0;
    chk("q.reti_redirect", 32'(redirect), 32'd1);
    chk("q.reti_pc", 32'(redirect_pc), 32'h500);
    step();
    chk("q.ret_id", 32'(cur_int_id), 32'd2);
    chk("q.ret_in_isr", 32'(in_isr), 32'd0);
    chk("q.ret_redirect", 32'(redirect), 32'd0);
    step();
    chk("q.accept_id5", 32'(cur_int_id), 32'd5);
    chk("q.accept_disabled", 32'(int_disabled), 32'd1);
    int_req = 1'b0;
    begin
      int n = 0;
      while (!redirect && n < 10) begin
        step();
        n++;
      end
      chk("q.take2_seen", 32'(redirect), 32'd1);
      chk("q.take2_latency", 32'(n), 32'd1);
      chk("q.take2_saved_pc", 32'(saved_pc), 32'h600);
      chk("q.take2_pc", 32'(redirect_pc), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
